// File: rtl/vga_pixel_fifo.sv
// vga_pixel_fifo: circular pixel buffer feeding a registered VGA RGB output with underflow tracking
module vga_pixel_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  input  logic                       video_on,
  input  logic                       flush,
  output logic [DATA_W-1:0]          rgb_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       underflow,
  input  logic                       underflow_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop, empty;
  assign empty    = level == '0;
  assign in_ready = level != FULL;
  assign push     = in_valid && in_ready;
  assign pop      = video_on && !empty;
  // storage array; contents survive reset and flush, only pointers are cleared
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  // pointers, occupancy, output register and sticky underflow; reset beats flush beats traffic
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rgb_data  <= '0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rgb_data  <= '0;
      underflow <= underflow && !underflow_clr;
    end else begin
      wr_ptr    <= wr_ptr + AW'(push);
      rd_ptr    <= rd_ptr + AW'(pop);
      level     <= level + (AW+1)'(push) - (AW+1)'(pop);
      rgb_data  <= pop ? mem[rd_ptr] : '0;
      underflow <= (video_on && empty) || (underflow && !underflow_clr);
    end
  end
endmodule

// File: tb/tb_vga_pixel_fifo.sv
// tb_vga_pixel_fifo: randomized and directed scoreboard bench against a queue-based pixel FIFO model
module tb_vga_pixel_fifo;
  localparam int DW = 12;
  localparam int DEPTH = 16;
  localparam int LW = $clog2(DEPTH) + 1;
  logic clk = 0;
  logic rst = 1, in_valid = 0, video_on = 0, flush = 0, underflow_clr = 0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, underflow;
  logic [DW-1:0] rgb_data;
  logic [LW-1:0] level;
  int vectors = 0, miscompares = 0;
  typedef struct {logic [DW-1:0] rgb; int lvl; bit uf; bit rdy;} exp_t;
  exp_t exp_q[$];
  logic [DW-1:0] model_q[$];
  bit model_uf = 0;
  vga_pixel_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .video_on(video_on), .flush(flush), .rgb_data(rgb_data), .level(level),
    .underflow(underflow), .underflow_clr(underflow_clr)
  );
  always #5 clk = ~clk;
  // apply one cycle of inputs and record what the FIFO should show after the next edge
  task automatic cyc(input bit r, input bit f, input bit v, input logic [DW-1:0] d, input bit vo, input bit clr);
    exp_t e;
    bit was_empty, was_full;
    @(negedge clk);
    rst = r; flush = f; in_valid = v; in_data = d; video_on = vo; underflow_clr = clr;
    e.rgb = '0;
    if (r) begin
      model_q.delete();
      model_uf = 0;
    end else if (f) begin
      model_q.delete();
      model_uf = model_uf && !clr;
    end else begin
      was_empty = model_q.size() == 0;
      was_full  = model_q.size() == DEPTH;
      if (vo && !was_empty) e.rgb = model_q.pop_front();
      if (v && !was_full) model_q.push_back(d);
      model_uf = (vo && was_empty) || (model_uf && !clr);
    end
    e.lvl = model_q.size();
    e.uf  = model_uf;
    e.rdy = model_q.size() != DEPTH;
    exp_q.push_back(e);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, 0, 0);
  endtask
  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, DW'(base + i), 0, 0);
  endtask
  // monitor: compare every post-edge output against the oldest pending expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        vectors += 4;
        if (rgb_data !== e.rgb) begin miscompares++; $display("FAIL rgb_data: got %h want %h at %0t", rgb_data, e.rgb, $time); end
        if (level !== LW'(e.lvl)) begin miscompares++; $display("FAIL level: got %0d want %0d at %0t", level, e.lvl, $time); end
        if (underflow !== e.uf) begin miscompares++; $display("FAIL underflow: got %b want %b at %0t", underflow, e.uf, $time); end
        if (in_ready !== e.rdy) begin miscompares++; $display("FAIL in_ready: got %b want %b at %0t", in_ready, e.rdy, $time); end
      end
    end
  end
  initial begin
    cyc(1, 0, 0, '0, 0, 0);
    cyc(1, 0, 0, '0, 0, 0);
    fill(16, 1);
    cyc(0, 0, 1, 12'h011, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, '0, 1, 0);
    idle(1);
    cyc(0, 0, 0, '0, 1, 0);
    idle(2);
    cyc(0, 0, 0, '0, 0, 1);
    idle(1);
    fill(15, 12'h100);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, DW'(12'h200 + i), 1, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, '0, 1, 0);
    cyc(0, 1, 1, 12'h3AA, 1, 0);
    idle(1);
    fill(8, 12'h400);
    cyc(1, 0, 1, 12'h4FF, 1, 0);
    idle(1);
    fill(4, 12'h500);
    cyc(0, 0, 0, '0, 1, 0);
    cyc(0, 0, 0, '0, 0, 0);
    cyc(0, 0, 0, '0, 1, 0);
    cyc(0, 0, 0, '0, 1, 0);
    cyc(0, 0, 0, '0, 1, 1);
    cyc(0, 0, 0, '0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      int p = int'($urandom_range(0, 99));
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0,
          $urandom_range(0, 99) < (p < 50 ? 80 : 40), DW'($urandom),
          $urandom_range(0, 99) < (p < 50 ? 40 : 75), $urandom_range(0, 19) == 0);
    end
    idle(1);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vga_pixel_fifo.md
VGA_PIXEL_FIFO -- requirements
Module: vga_pixel_fifo

Interface
REQ-001 Parameter DATA_W, default 12: pixel width in bits (RGB 4:4:4).
REQ-002 Parameter DEPTH, default 16: FIFO entries; it SHALL be a power of two, at least 4.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 rst  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1: upstream pixel source offers in_data.
REQ-006 in_data  input  DATA_W: pixel value offered upstream.
REQ-007 in_ready  output  1: FIFO can accept a pixel this cycle.
REQ-008 video_on  input  1: from the VGA timing controller; 1 = active display pixel this cycle.
REQ-009 flush  input  1: synchronous discard of all stored pixels (driven at frame start).
REQ-010 rgb_data  output  DATA_W: registered pixel to the VGA output stage.
REQ-011 level  output  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-012 underflow  output  1: sticky flag, set when a pixel is needed but the FIFO is empty.
REQ-013 underflow_clr  input  1: clears the underflow flag.

Function
REQ-014 Storage SHALL be a circular buffer with write pointer, read pointer and occupancy counter; pointers wrap from DEPTH-1 to 0.
REQ-015 in_ready SHALL equal (level != DEPTH); it SHALL be derived from registered state only and SHALL NOT depend on in_valid or video_on.
REQ-016 Push occurs when in_valid && in_ready: in_data is written at the write pointer; the write pointer advances.
REQ-017 Pop occurs when video_on && level != 0: the entry at the read pointer is loaded into rgb_data on the same edge; the read pointer advances.
REQ-018 Latency: a pixel popped on edge N SHALL appear on rgb_data from edge N until edge N+1; rgb_data is one register stage behind video_on.
REQ-019 When video_on = 0 at an edge, rgb_data SHALL load 0. Every cycle after a cycle with video_on = 0 therefore shows rgb_data = 0.
REQ-020 When video_on = 1 and level = 0 at an edge, rgb_data SHALL load 0 and underflow SHALL be set to 1.
REQ-021 Simultaneous push and pop SHALL leave level unchanged. This includes level = DEPTH-1, and level = 0 does not qualify as a pop.
REQ-022 A push is never accepted at level = DEPTH, even when a pop occurs on the same edge.
REQ-023 level SHALL update each edge as +1 for push only, -1 for pop only, and 0 otherwise; it SHALL never exceed DEPTH or go below 0.
REQ-024 flush = 1 SHALL reset both pointers and level to 0 and discard any push or pop on that edge.
REQ-025 During flush, rgb_data SHALL load 0, and underflow SHALL NOT be set by that edge.
REQ-026 underflow_clr = 1 SHALL clear underflow on that edge. If a set condition occurs on the same edge, set wins and underflow = 1.
REQ-027 Stored data contents are not reset; only pointers, counters, and outputs are reset.

Reset
REQ-028 While rst = 1 at an edge: pointers = 0, level = 0, rgb_data = 0, underflow = 0; in_ready = 1 on the following cycle.
REQ-029 rst SHALL take priority over flush, push, pop and underflow_clr.
REQ-030 A reset asserted mid-line SHALL discard all stored pixels. After reset is released, the first pixel accepted SHALL be the first pixel output.

Verification
REQ-031 Fill test: rst, then push 0x001..0x010 with video_on = 0. Required: in_ready = 0 after the 16th push, level = 16, rgb_data = 0 throughout, and a 17th offer is not accepted.
REQ-032 Ordering test: full FIFO, then video_on = 1 for 16 cycles. Required: rgb_data = 0x001..0x010 on consecutive cycles with one-cycle lag, and level = 0 at the end.
REQ-033 Underflow test: empty FIFO with video_on = 1 for 1 cycle. Required: rgb_data = 0 and underflow = 1 and held. Then underflow_clr = 1 for 1 cycle with video_on = 0. Required: underflow = 0.
REQ-034 Concurrent test: level = 15, in_valid = 1 and video_on = 1 for 10 cycles. Required: level stays 15, in_ready = 1, and output order is preserved across pointer wrap.
REQ-035 Flush and reset test: level = 8, flush = 1 together with in_valid = 1 and video_on = 1. Required: next level = 0, rgb_data = 0, underflow = 0. Repeat with rst = 1 in place of flush: same result, in_ready = 1.
REQ-036 Blanking test: level = 4 and a video_on pattern 1,0,1,1. Required: rgb_data = d0, 0, d1, d2 and level = 1.
